// File: rtl/lc3_writeback_pkg.sv
// Shared types, widths and the condition-code helper for the LC3 writeback stage.
// The PSR function is also used by anything that predicts the stage's behaviour.
package lc3_wb_pkg;

   localparam int DATA_W   = 16;
   localparam int NUM_REGS = 8;
   localparam int ADDR_W   = $clog2(NUM_REGS);

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC  = 2'd2,
      WB_NPC = 2'd3
   } w_ctrl_e;

   localparam int PSR_N = 2;
   localparam int PSR_Z = 1;
   localparam int PSR_P = 0;

   // Exactly one bit of the result is set for any input value.
   function automatic logic [2:0] calc_psr(input logic [DATA_W-1:0] value);
      logic [2:0] cc;
      cc        = 3'b000;
      cc[PSR_N] = value[DATA_W-1];
      cc[PSR_Z] = (value == '0);
      cc[PSR_P] = !value[DATA_W-1] && (value != '0);
      return cc;
   endfunction

endpackage

// File: rtl/lc3_writeback_if.sv
// The writeback_in bus: write controls and result candidates from the pipeline,
// plus the two register read ports and the condition code returned to execute.
interface lc3_writeback_if;
   import lc3_wb_pkg::*;

   // enable_writeback qualifies the write fields for one rising edge; there is
   // no ready signal because the stage accepts a write on every cycle.
   logic              enable_writeback;
   logic [1:0]        W_control_in;
   logic [DATA_W-1:0] aluout;
   logic [DATA_W-1:0] memout;
   logic [DATA_W-1:0] pcout;
   logic [DATA_W-1:0] npc;
   logic [ADDR_W-1:0] dr;
   logic [ADDR_W-1:0] sr1;
   logic [ADDR_W-1:0] sr2;
   logic [DATA_W-1:0] d1;
   logic [DATA_W-1:0] d2;
   logic [2:0]        psr;

   modport master (
      output enable_writeback,
      output W_control_in,
      output aluout,
      output memout,
      output pcout,
      output npc,
      output dr,
      output sr1,
      output sr2,
      input  d1,
      input  d2,
      input  psr
   );

   modport slave (
      input  enable_writeback,
      input  W_control_in,
      input  aluout,
      input  memout,
      input  pcout,
      input  npc,
      input  dr,
      input  sr1,
      input  sr2,
      output d1,
      output d2,
      output psr
   );

endinterface

// File: rtl/lc3_writeback_regfile.sv
// General-purpose register file: one synchronous write port with active-low
// synchronous clear and two combinational read ports (no write-to-read bypass).
module lc3_regfile
   import lc3_wb_pkg::*;
#(
   parameter int DATA_W_P   = DATA_W,
   parameter int NUM_REGS_P = NUM_REGS,
   parameter int ADDR_W_P   = $clog2(NUM_REGS_P)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                we,
   input  logic [ADDR_W_P-1:0] waddr,
   input  logic [DATA_W_P-1:0] wdata,
   input  logic [ADDR_W_P-1:0] raddr1,
   input  logic [ADDR_W_P-1:0] raddr2,
   output logic [DATA_W_P-1:0] rdata1,
   output logic [DATA_W_P-1:0] rdata2
);

   logic [DATA_W_P-1:0] regs_q [NUM_REGS_P];
   logic [DATA_W_P-1:0] regs_d [NUM_REGS_P];

   // Clear takes priority over a write presented in the same cycle.
   always_comb begin
      for (int i = 0; i < NUM_REGS_P; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS_P; i++) begin
            regs_d[i] = '0;
         end
      end else if (we) begin
         regs_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REGS_P; i++) begin
         regs_q[i] <= regs_d[i];
      end
   end

   assign rdata1 = regs_q[raddr1];
   assign rdata2 = regs_q[raddr2];

endmodule

// File: rtl/lc3_writeback.sv
// LC3 writeback stage: selects the result to retire, writes it to the register
// file and updates the N/Z/P condition code from the same value.
module lc3_writeback
   import lc3_wb_pkg::*;
#(
   parameter int DATA_W_P   = DATA_W,
   parameter int NUM_REGS_P = NUM_REGS
) (
   input  logic          clock,
   input  logic          reset,
   lc3_writeback_if.slave wb
);

   w_ctrl_e           w_sel;
   logic [DATA_W-1:0] wb_data;
   logic [2:0]        psr_d;
   logic [2:0]        psr_q;

   assign w_sel = w_ctrl_e'(wb.W_control_in);

   always_comb begin
      wb_data = wb.aluout;
      case (w_sel)
         WB_ALU:  wb_data = wb.aluout;
         WB_MEM:  wb_data = wb.memout;
         WB_PC:   wb_data = wb.pcout;
         WB_NPC:  wb_data = wb.npc;
         default: wb_data = wb.aluout;
      endcase
   end

   // 3'b000 marks "no write since reset"; any write leaves exactly one bit set.
   always_comb begin
      psr_d = psr_q;
      if (!reset) begin
         psr_d = 3'b000;
      end else if (wb.enable_writeback) begin
         psr_d = calc_psr(wb_data);
      end
   end

   always_ff @(posedge clock) begin
      psr_q <= psr_d;
   end

   assign wb.psr = psr_q;

   lc3_regfile #(
      .DATA_W_P   (DATA_W_P),
      .NUM_REGS_P (NUM_REGS_P),
      .ADDR_W_P   (ADDR_W)
   ) u_regfile (
      .clk    (clock),
      .rst_n  (reset),
      .we     (wb.enable_writeback),
      .waddr  (wb.dr),
      .wdata  (wb_data),
      .raddr1 (wb.sr1),
      .raddr2 (wb.sr2),
      .rdata1 (wb.d1),
      .rdata2 (wb.d2)
   );

endmodule

// File: tb/tb_lc3_writeback.sv
// Bench for lc3_writeback: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an array-based model.
module tb_lc3_writeback;

   logic clock;
   logic reset;
   int   checks;
   int   errors;
   bit   cmp_en;

   logic [15:0] model_r [8];
   logic [2:0]  model_psr;

   lc3_writeback_if wb_bus ();

   lc3_writeback dut (
      .clock (clock),
      .reset (reset),
      .wb    (wb_bus.slave)
   );

   // ---------------- clock ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- scoreboard helpers ----------------
   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] model_cc(input logic [15:0] v);
      if (v == 16'd0)           return 3'b010;
      else if ($signed(v) < 0)  return 3'b100;
      else                      return 3'b001;
   endfunction

   // Advances one rising edge, applies the architectural effect of the inputs
   // present at that edge to the model, then steps off the edge.
   task automatic cycle();
      logic [15:0] src [4];
      @(posedge clock);
      src[0] = wb_bus.aluout;
      src[1] = wb_bus.memout;
      src[2] = wb_bus.pcout;
      src[3] = wb_bus.npc;
      if (!reset) begin
         for (int i = 0; i < 8; i++) model_r[i] = 16'd0;
         model_psr = 3'b000;
      end else if (wb_bus.enable_writeback) begin
         model_r[wb_bus.dr] = src[wb_bus.W_control_in];
         model_psr          = model_cc(src[wb_bus.W_control_in]);
      end
      #1;
   endtask

   task automatic drive_write(input logic en, input logic [1:0] ctrl, input logic [2:0] dr,
                              input logic [15:0] alu, input logic [15:0] mem,
                              input logic [15:0] pc, input logic [15:0] np);
      wb_bus.enable_writeback = en;
      wb_bus.W_control_in     = ctrl;
      wb_bus.dr               = dr;
      wb_bus.aluout           = alu;
      wb_bus.memout           = mem;
      wb_bus.pcout            = pc;
      wb_bus.npc              = np;
   endtask

   // ---------------- per-cycle compare against the model ----------------
   always @(negedge clock) begin
      if (cmp_en) begin
         chk("cmp_d1",  wb_bus.d1, model_r[wb_bus.sr1]);
         chk("cmp_d2",  wb_bus.d2, model_r[wb_bus.sr2]);
         chk("cmp_psr", {13'd0, wb_bus.psr}, {13'd0, model_psr});
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [15:0] sel_exp [4];
      logic [2:0]  psr_exp [4];
      checks = 0;
      errors = 0;
      cmp_en = 1'b0;
      for (int i = 0; i < 8; i++) model_r[i] = 16'hxxxx;
      model_psr = 3'bxxx;
      wb_bus.sr1 = 3'd0;
      wb_bus.sr2 = 3'd0;

      // Reset held for two cycles while a write is requested.
      reset = 1'b0;
      drive_write(1'b1, 2'd0, 3'd3, 16'h1234, 16'h0, 16'h0, 16'h0);
      cycle();
      cmp_en = 1'b1;
      cycle();
      reset = 1'b1;
      wb_bus.enable_writeback = 1'b0;
      for (int i = 0; i < 8; i++) begin
         wb_bus.sr1 = 3'(i);
         wb_bus.sr2 = 3'(7 - i);
         #1;
         chk("reset_d1", wb_bus.d1, 16'h0000);
         chk("reset_d2", wb_bus.d2, 16'h0000);
      end
      chk("reset_psr", {13'd0, wb_bus.psr}, 16'h0000);

      // Every write-data select, into R1.
      sel_exp = '{16'h0005, 16'h8000, 16'h0000, 16'h3001};
      psr_exp = '{3'b001, 3'b100, 3'b010, 3'b001};
      wb_bus.sr1 = 3'd1;
      for (int s = 0; s < 4; s++) begin
         drive_write(1'b1, 2'(s), 3'd1, 16'h0005, 16'h8000, 16'h0000, 16'h3001);
         cycle();
         chk("sel_d1",  wb_bus.d1, sel_exp[s]);
         chk("sel_psr", {13'd0, wb_bus.psr}, {13'd0, psr_exp[s]});
      end

      // Read during write: old value until the edge, new value after.
      drive_write(1'b1, 2'd0, 3'd4, 16'h00AA, 16'h0, 16'h0, 16'h0);
      cycle();
      wb_bus.sr1    = 3'd4;
      wb_bus.aluout = 16'h00BB;
      #1;
      chk("rdw_old", wb_bus.d1, 16'h00AA);
      cycle();
      chk("rdw_new", wb_bus.d1, 16'h00BB);

      // Enable low: nothing changes.
      drive_write(1'b0, 2'd0, 3'd2, 16'hFFFF, 16'h0, 16'h0, 16'h0);
      wb_bus.sr1 = 3'd2;
      for (int c = 0; c < 5; c++) begin
         cycle();
         chk("hold_r2",  wb_bus.d1, 16'h0000);
         chk("hold_psr", {13'd0, wb_bus.psr}, 16'h0001);
      end

      // Fill all registers, dual-port sweep.
      for (int i = 0; i < 8; i++) begin
         drive_write(1'b1, 2'd0, 3'(i), 16'h1000 + 16'(i), 16'h0, 16'h0, 16'h0);
         cycle();
      end
      wb_bus.enable_writeback = 1'b0;
      for (int i = 0; i < 8; i++) begin
         wb_bus.sr1 = 3'(i);
         wb_bus.sr2 = 3'(7 - i);
         #1;
         chk("fill_d1", wb_bus.d1, 16'h1000 + 16'(i));
         chk("fill_d2", wb_bus.d2, 16'h1007 - 16'(i));
      end

      // Reset lands on a write: the write is lost and everything clears.
      drive_write(1'b1, 2'd0, 3'd5, 16'h7777, 16'h0, 16'h0, 16'h0);
      reset = 1'b0;
      cycle();
      reset = 1'b1;
      wb_bus.enable_writeback = 1'b0;
      for (int i = 0; i < 8; i++) begin
         wb_bus.sr1 = 3'(i);
         wb_bus.sr2 = 3'(7 - i);
         #1;
         chk("midrst_d1", wb_bus.d1, 16'h0000);
         chk("midrst_d2", wb_bus.d2, 16'h0000);
      end
      chk("midrst_psr", {13'd0, wb_bus.psr}, 16'h0000);

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 400; c++) begin
         logic [15:0] v [4];
         for (int k = 0; k < 4; k++) begin
            case ($urandom_range(0, 7))
               0:       v[k] = 16'h0000;
               1:       v[k] = 16'h8000;
               default: v[k] = 16'($urandom);
            endcase
         end
         drive_write(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                     3'($urandom_range(0, 7)), v[0], v[1], v[2], v[3]);
         wb_bus.sr1 = 3'($urandom_range(0, 7));
         wb_bus.sr2 = ($urandom_range(0, 5) == 0) ? wb_bus.sr1 : 3'($urandom_range(0, 7));
         reset      = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
         cycle();
      end
      reset = 1'b1;
      wb_bus.enable_writeback = 1'b0;
      cycle();
      @(negedge clock);
      cmp_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lc3_writeback.md
# lc3_writeback

Writeback stage of the LC3 pipeline; it consumes the signals driven on the writeback_in bus. Each cycle it can select one result (ALU, memory, PC or NPC) and write it into the 8×16 general-purpose register file. It updates the 3-bit condition code (PSR: N/Z/P) from the written value. Two combinational read ports (sr1, sr2) supply operand values to the execute stage.

## Interface
Parameters:
- DATA_W, 16, register and data-path width
- NUM_REGS, 8, register file depth; addresses are 3 bits

Ports:
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-low; sampled on rising edge of clock
- enable_writeback  input  1  qualifies a register-file/PSR write this cycle
- W_control_in  input  2  write-data select: 0 aluout, 1 memout, 2 pcout, 3 npc
- aluout  input  16  execute-stage result
- memout  input  16  memory-access result
- pcout  input  16  computed address/PC result
- npc  input  16  next PC (link value)
- dr  input  3  destination register index
- sr1  input  3  read port 1 index
- sr2  input  3  read port 2 index
- d1  output  16  contents of R[sr1]
- d2  output  16  contents of R[sr2]
- psr  output  3  condition code {N,Z,P}

## Operation
- Write data: wb_data = mux(W_control_in; aluout, memout, pcout, npc). All four encodings are legal.
- When enable_writeback=1 at a rising edge with reset=1:
  - R[dr] <= wb_data.
  - psr is set from wb_data: N=wb_data[15]; Z=(wb_data==0); P=!wb_data[15] && wb_data!=0.
  - Exactly one PSR bit is set after any write.
- When enable_writeback=0: register file and psr hold.
- Reads: d1=R[sr1] and d2=R[sr2] are asynchronous/combinational. sr1==sr2 is legal; both outputs show the same value.
- No write bypass. If sr1/sr2 equals dr in the write cycle, d1/d2 show the old value until after the edge. The new value appears in the following cycle.
- All 8 registers, including R0, are writable. R0 has no hardwired zero.
- PSR reflects the most recent write only. Reads never affect PSR.

## Timing
- Reset: when reset=0 at a rising edge, all R[0..7] <= 0 and psr <= 3'b000.
  - Consequently d1=d2=0 after reset.
  - psr=000 is the defined "no write yet" state.
- Reset dominates enable_writeback in the same cycle; the write is discarded.
- Reset asserted between back-to-back writes clears everything. Writes after reset is released behave as from power-on.
- Write latency: 1 cycle. Data presented at edge k is visible on d1/d2 and psr after edge k.
- Back-to-back writes to the same dr: the last one wins. PSR follows each write.
- Inputs other than the reads have no combinational path to outputs. d1/d2 depend combinationally only on sr1/sr2 and register state.

## Structure
- Package lc3_wb_pkg:
  - enum w_ctrl_e {WB_ALU=0, WB_MEM=1, WB_PC=2, WB_NPC=3}
  - PSR bit index constants PSR_N=2, PSR_Z=1, PSR_P=0
  - function calc_psr(logic [15:0]) returning 3 bits, shared with the predictor/scoreboard
- Sub-module lc3_regfile: 8×16, one synchronous write port with active-low sync reset, two async read ports.
- The top level holds the write-data mux and the psr register.

## Test plan
- Reset: drive reset=0 for 2 cycles with enable_writeback=1, aluout=16'h1234, dr=3 → all d1/d2 reads return 0 and psr=000.
- Select coverage: write R1 with W_control_in=0,1,2,3 in successive cycles (aluout=16'h0005, memout=16'h8000, pcout=16'h0000, npc=16'h3001) with sr1=1 → d1 after each edge = 0005, 8000, 0000, 3001; psr = 001, 100, 010, 001.
- Read-during-write: sr1=dr=4, R4 holds 16'h00AA, write aluout=16'h00BB → d1=00AA in the write cycle and 00BB the next cycle.
- Enable low: enable_writeback=0, aluout=16'hFFFF, dr=2 for 5 cycles → R2 and psr unchanged.
- Dual read and reset mid-stream: fill R0..R7 with 16'h1000+i; sweep sr1=i, sr2=7-i → d1=1000+i and d2=1007-i. Assert reset for one cycle during the next write → all registers 0, psr=000, and the write is lost.
